// File: rtl/ghost_chase_driver.sv
// ghost_chase_driver: autonomous active-low w/a/s/d strobe generator steering a ghost to player or scatter corner.
`ifndef DIR_UP
`define DIR_UP    2'd0
`define DIR_DOWN  2'd1
`define DIR_LEFT  2'd2
`define DIR_RIGHT 2'd3
`endif
module ghost_chase_driver #(
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int MOVE_DIV      = 4,
  parameter int HOLD_STEPS    = 2,
  parameter int CHASE_TICKS   = 8,
  parameter int SCATTER_TICKS = 4,
  parameter int SCATTER_X     = 0,
  parameter int SCATTER_Y     = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  output logic           w,
  output logic           a,
  output logic           s,
  output logic           d,
  output logic [1:0]     dir_out,
  output logic           mode
);
  localparam int W  = (X_W > Y_W ? X_W : Y_W) + 1;
  localparam int CW = $clog2(MOVE_DIV);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam int MW = $clog2((CHASE_TICKS > SCATTER_TICKS ? CHASE_TICKS : SCATTER_TICKS) + 1);
  typedef enum logic {chase_st, scatter_st} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic [MW-1:0] mcnt, mcnt_n;
  logic [1:0] dir_n, new_dir, use_dir;
  logic [3:0] stb_n;
  logic [X_W-1:0] tx;
  logic [Y_W-1:0] ty;
  logic [X_W:0] dx, ax;
  logic [Y_W:0] dy, ay;
  logic tick, held_zero, redecide, none, x_axis, flip, mode_done;
  function automatic logic [3:0] to_stb(input logic [1:0] dir);
    return dir == `DIR_UP ? 4'b0111 : dir == `DIR_LEFT ? 4'b1011 :
           dir == `DIR_DOWN ? 4'b1101 : 4'b1110;
  endfunction
  assign tick = enable && cnt == CW'(MOVE_DIV - 1);
  assign tx = st == scatter_st ? X_W'(SCATTER_X) : player_x;
  assign ty = st == scatter_st ? Y_W'(SCATTER_Y) : player_y;
  assign dx = {1'b0, tx} - {1'b0, ghost_x};
  assign dy = {1'b0, ty} - {1'b0, ghost_y};
  assign ax = dx[X_W] ? -dx : dx;
  assign ay = dy[Y_W] ? -dy : dy;
  assign none = dx == '0 && dy == '0;
  assign held_zero = (dir_out == `DIR_LEFT || dir_out == `DIR_RIGHT) ? dx == '0 : dy == '0;
  assign redecide = hold == '0 || held_zero;
  assign x_axis = (W'(ax) >= W'(ay)) ^ (flip && dx != '0 && dy != '0);
  assign new_dir = x_axis ? (dx[X_W] ? `DIR_LEFT : `DIR_RIGHT) : (dy[Y_W] ? `DIR_UP : `DIR_DOWN);
  assign use_dir = redecide ? new_dir : dir_out;
  assign mode_done = st == chase_st ? mcnt == MW'(CHASE_TICKS - 1) : mcnt == MW'(SCATTER_TICKS - 1);
  assign mode = st == scatter_st;
`ifdef GHOST_CHASE_JITTER_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr <= 8'hA5;
    else if (tick) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign flip = lfsr[0];
`else
  assign flip = 1'b0;
`endif
  always_comb begin
    cnt_n = enable ? (tick ? '0 : cnt + 1'b1) : '0;
    hold_n = enable ? hold : '0;
    mcnt_n = enable ? mcnt : '0;
    st_n = enable ? st : chase_st;
    dir_n = dir_out;
    stb_n = 4'hF;
    if (tick) begin
      if (none) hold_n = '0;
      else begin
        dir_n = use_dir;
        stb_n = to_stb(use_dir);
        hold_n = redecide ? HW'(HOLD_STEPS - 1) : hold - 1'b1;
      end
      mcnt_n = mode_done ? '0 : mcnt + 1'b1;
      if (mode_done) begin
        st_n = st == chase_st ? scatter_st : chase_st;
        hold_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= chase_st;
      cnt <= '0;
      hold <= '0;
      mcnt <= '0;
      dir_out <= `DIR_LEFT;
      {w, a, s, d} <= 4'hF;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      hold <= hold_n;
      mcnt <= mcnt_n;
      dir_out <= dir_n;
      {w, a, s, d} <= stb_n;
    end
endmodule

// File: tb/tb_ghost_chase_driver.sv
// tb_ghost_chase_driver: scoreboard bench; stimulus queues expected strobes, a negedge monitor checks them.
`ifndef DIR_UP
`define DIR_UP    2'd0
`define DIR_DOWN  2'd1
`define DIR_LEFT  2'd2
`define DIR_RIGHT 2'd3
`endif
module tb_ghost_chase_driver;
  logic clk = 0, reset = 0, enable = 0;
  logic [9:0] ghost_x = 100, player_x = 200;
  logic [8:0] ghost_y = 100, player_y = 150;
  logic w, a, s, d, mode;
  logic [1:0] dir_out;
  int tests = 0, fails = 0, cyc = 0, e0 = 0;
  typedef struct {int cyc; logic [3:0] wasd; logic [1:0] dir; logic mode;} exp_t;
  exp_t q[$];
  ghost_chase_driver dut (.clk(clk), .reset(reset), .enable(enable), .ghost_x(ghost_x),
    .ghost_y(ghost_y), .player_x(player_x), .player_y(player_y), .w(w), .a(a), .s(s),
    .d(d), .dir_out(dir_out), .mode(mode));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [3:0] stb_of(input logic [1:0] dir);
    case (dir)
      `DIR_UP:   return 4'b0111;
      `DIR_LEFT: return 4'b1011;
      `DIR_DOWN: return 4'b1101;
      default:   return 4'b1110;
    endcase
  endfunction
  task automatic expect_at(input int k, input logic [1:0] dir, input logic m);
    exp_t e;
    e.cyc = e0 + 4 * k;
    e.wasd = stb_of(dir);
    e.dir = dir;
    e.mode = m;
    q.push_back(e);
  endtask
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic start();
    @(negedge clk);
    enable = 1;
    e0 = cyc;
  endtask
  always @(negedge clk)
    if ({w, a, s, d} != 4'hF) begin
      tests++;
      if ($countones(~{w, a, s, d}) != 1) begin
        fails++;
        $display("FAIL onehot: wasd=%b at cycle %0d", {w, a, s, d}, cyc);
      end
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected strobe: wasd=%b dir=%0d at cycle %0d", {w, a, s, d}, dir_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.wasd != {w, a, s, d} || e.dir != dir_out || e.mode != mode) begin
          fails++;
          $display("FAIL strobe: got cyc=%0d wasd=%b dir=%0d mode=%0d expected cyc=%0d wasd=%b dir=%0d mode=%0d",
                   cyc, {w, a, s, d}, dir_out, mode, e.cyc, e.wasd, e.dir, e.mode);
        end
      end
    end
  initial begin
    repeat (3) @(negedge clk);
    check("reset_wasd", {w, a, s, d}, 4'hF);
    check("reset_dir", dir_out, `DIR_LEFT);
    check("reset_mode", mode, 0);
    reset = 1;
    start();
    for (int k = 1; k <= 3; k++) expect_at(k, `DIR_RIGHT, 0);
    repeat (13) @(negedge clk);
    enable = 0;
    @(negedge clk);
    check("disable_wasd", {w, a, s, d}, 4'hF);
    check("disable_mode", mode, 0);
    player_x = 50;
    start();
    expect_at(1, `DIR_LEFT, 0);
    expect_at(2, `DIR_LEFT, 0);
    repeat (9) @(negedge clk);
    enable = 0;
    player_x = 100; player_y = 100;
    start();
    repeat (22) @(negedge clk);
    check("equal_dir_held", dir_out, `DIR_LEFT);
    check("equal_mode", mode, 0);
    enable = 0;
    player_x = 200; player_y = 150;
    start();
    expect_at(1, `DIR_RIGHT, 0);
    repeat (4) @(negedge clk);
    player_x = 110; player_y = 300;
    expect_at(2, `DIR_RIGHT, 0);
    expect_at(3, `DIR_DOWN, 0);
    repeat (9) @(negedge clk);
    enable = 0;
    player_x = 200; player_y = 150;
    start();
    expect_at(1, `DIR_RIGHT, 0);
    repeat (4) @(negedge clk);
    player_x = 100;
    expect_at(2, `DIR_DOWN, 0);
    repeat (5) @(negedge clk);
    enable = 0;
    ghost_y = 120; player_x = 200; player_y = 150;
    start();
    for (int k = 1; k <= 7; k++) expect_at(k, `DIR_RIGHT, 0);
    expect_at(8, `DIR_RIGHT, 1);
    for (int k = 9; k <= 11; k++) expect_at(k, `DIR_UP, 1);
    expect_at(12, `DIR_UP, 0);
    expect_at(13, `DIR_RIGHT, 0);
    repeat (53) @(negedge clk);
    enable = 0;
    start();
    for (int k = 1; k <= 7; k++) expect_at(k, `DIR_RIGHT, 0);
    expect_at(8, `DIR_RIGHT, 1);
    expect_at(9, `DIR_UP, 1);
    repeat (36) @(negedge clk);
    check("scatter_mode", mode, 1);
    enable = 0;
    @(negedge clk);
    check("midrun_off_wasd", {w, a, s, d}, 4'hF);
    check("midrun_off_mode", mode, 0);
    check("midrun_off_dir", dir_out, `DIR_UP);
    ghost_y = 100;
    start();
    expect_at(1, `DIR_RIGHT, 0);
    repeat (4) @(negedge clk);
    #1 reset = 0;
    #1;
    check("async_wasd", {w, a, s, d}, 4'hF);
    check("async_dir", dir_out, `DIR_LEFT);
    check("async_mode", mode, 0);
    @(negedge clk);
    reset = 1;
    e0 = cyc;
    expect_at(1, `DIR_RIGHT, 0);
    repeat (5) @(negedge clk);
    enable = 0;
    repeat (3) @(negedge clk);
    check("missing_strobes", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
